adau_spi_burst_master: RTL and testbench
========================================

// Module: adau_spi_burst_master
// PURPOSE
//   Parametrised SPI control-port master for the ADAU audio codec; successor to the fixed 32-bit write-only master.
//   Sends one framed transaction per accepted command: {CHIP_ADDR,RW}, a 16-bit register address, then 1..MAX_BYTES data bytes.
//   Supports both writes and reads; read data is captured from the codec's COUT pin.
//   Issues the codec's SPI-mode entry latch pulses after reset.
//   Sits between the register-init sequencer and the codec pins (cdata/cclk/clatch_n).
// PARAMETERS
//   CLK_DIV      8      clk cycles per cclk half-period (>=1)
//   MAX_BYTES    4      max data bytes per frame (>=1); LW = $clog2(MAX_BYTES)+1
//   CHIP_ADDR    7'h00  7-bit chip address placed in frame bits [7:1] of the first byte
//   INIT_PULSES  3      clatch_n low pulses issued after reset (0 = none)
//   LATCH_GAP    4      min clk cycles clatch_n stays high between frames/pulses (>=1)
// PORTS
//   clk         in   1             system clock; single clock domain
//   reset       in   1             synchronous, active-high reset
//   cmd_valid   in   1             command offered
//   cmd_ready   out  1             block can accept a command
//   cmd_rw      in   1             1 = read, 0 = write (sent as RW bit)
//   cmd_addr    in   16            codec register address, MSB first
//   cmd_nbytes  in   LW            number of data bytes, legal range 1..MAX_BYTES
//   cmd_wdata   in   8*MAX_BYTES   write bytes; byte k in [8k+7:8k], byte 0 sent first
//   rsp_valid   out  1             one-cycle pulse at end of each accepted command
//   rsp_err     out  1             qualifies rsp_valid: illegal cmd_nbytes, no frame sent
//   rsp_rdata   out  8*MAX_BYTES   read bytes, byte k in [8k+7:8k]; unreceived bytes = 0
//   cout        in   1             codec serial data out
//   cdata       out  1             serial data to codec
//   cclk        out  1             serial clock; idles high
//   clatch_n    out  1             frame latch, active low
//   busy        out  1             high in any state other than IDLE
//   led         out  3             debug: {init_done, busy, last rsp_err}
// BEHAVIOUR
//   Reset values: cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, cdata=0, cclk=1, clatch_n=1, busy=1, led=0.
//   Reset takes effect on the next clk edge from any state; a frame in progress is aborted (clatch_n=1, cclk=1), with no rsp_valid.
//   States: INIT_LO -> INIT_HI (repeated INIT_PULSES times) -> IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//   INIT_LO: clatch_n=0 for 2*CLK_DIV cycles; cclk stays high, cdata stays 0.
//   INIT_HI: clatch_n=1 for LATCH_GAP cycles.
//   If INIT_PULSES=0, the block enters IDLE one cycle after reset deasserts.
//   IDLE: cmd_ready=1. Handshake completes on a cycle where cmd_valid && cmd_ready; all cmd_* fields are registered in that cycle.
//   cmd_ready drops the cycle after acceptance and stays 0 until the block is back in IDLE.
//   Illegal cmd_nbytes (0 or >MAX_BYTES): rsp_valid=1, rsp_err=1 the next cycle; stay in IDLE; no pin activity.
//   Frame length NB = 24 + 8*cmd_nbytes bits, MSB first per field:
//     {CHIP_ADDR, rw}, addr[15:8], addr[7:0], byte0..byte(N-1).
//   SETUP (entered the cycle after acceptance): clatch_n=0, cdata=bit0, cclk=1; lasts CLK_DIV cycles.
//   SHIFT, per bit i:
//     - cclk=0 for CLK_DIV cycles; cdata updates to bit i at the start of the low phase (bit0 was already driven in SETUP).
//     - then cclk=1 for CLK_DIV cycles.
//     - cout is sampled on the clk edge where cclk rises.
//   Reads: master drives cdata=0 during data bytes; cout bits shift into byte k MSB first. Writes: cout is ignored.
//   HOLD: after the last high phase, clatch_n stays 0 and cclk stays 1 for CLK_DIV cycles.
//   Then clatch_n rises. In that same cycle: rsp_valid=1, rsp_err=0, and rsp_rdata is updated (reads only).
//   rsp_rdata holds its value until the next read response or reset.
//   clatch_n low duration = CLK_DIV*(2 + 2*NB) cycles exactly.
//   GAP: clatch_n=1 for LATCH_GAP cycles, then IDLE.
//   Back-to-back commands: clatch_n rise-to-fall spacing = LATCH_GAP + 1 cycles.
//   Counters: the bit counter must cover 24+8*MAX_BYTES; the divider counter must cover 0..CLK_DIV-1. Neither wraps mid-frame.
// TESTING
//   1 Reset with INIT_PULSES=3, CLK_DIV=2, LATCH_GAP=4 -> 3 clatch_n low pulses of 4 cycles each, 4 cycles high between; cmd_ready rises after the last gap; cclk constant 1.
//   2 Write CHIP_ADDR=0, addr=16'h4000, nbytes=1, wdata=8'h01, CLK_DIV=2 -> cdata stream 32'h00400001 sampled on cclk rise; clatch_n low 132 cycles; one rsp_valid, rsp_err=0.
//   3 Read addr=16'h4002, nbytes=2; bench codec returns 8'hA5 then 8'h3C -> first byte = 8'h01, rsp_rdata[15:0] = 16'h3CA5, upper bytes 0.
//   4 cmd_nbytes=0, then cmd_nbytes=MAX_BYTES+1 -> each gives an rsp_valid/rsp_err pulse the following cycle; clatch_n and cclk never toggle.
//   5 Hold cmd_valid high across two write commands -> second accepted only in IDLE; clatch_n rise-to-fall = LATCH_GAP+1 cycles.
//   6 Assert reset mid-SHIFT (bit 10) -> next cycle clatch_n=1, cclk=1, no rsp_valid; the init pulse sequence replays.

Source files
------------

// File: rtl/adau_spi_burst_master.sv
// SPI control-port master for the ADAU codec: init latch pulses, then framed
// read/write bursts of {CHIP_ADDR,RW}, 16-bit register address and 1..MAX_BYTES data bytes.
module adau_spi_burst_master #(
  parameter int          CLK_DIV     = 8,
  parameter int          MAX_BYTES   = 4,
  parameter logic [6:0]  CHIP_ADDR   = 7'h00,
  parameter int          INIT_PULSES = 3,
  parameter int          LATCH_GAP   = 4,
  localparam int         LW          = $clog2(MAX_BYTES) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_rw,
  input  logic [15:0]            cmd_addr,
  input  logic [LW-1:0]          cmd_nbytes,
  input  logic [8*MAX_BYTES-1:0] cmd_wdata,
  output logic                   rsp_valid,
  output logic                   rsp_err,
  output logic [8*MAX_BYTES-1:0] rsp_rdata,
  input  logic                   cout,
  output logic                   cdata,
  output logic                   cclk,
  output logic                   clatch_n,
  output logic                   busy,
  output logic [2:0]             led
);

  localparam int DW   = 8 * MAX_BYTES;
  localparam int SW   = 24 + DW;
  localparam int BW   = $clog2(SW + 1);
  localparam int TMAX = (2 * CLK_DIV > LATCH_GAP) ? 2 * CLK_DIV : LATCH_GAP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = (INIT_PULSES > 1) ? $clog2(INIT_PULSES) : 1;
  localparam int RXW  = $clog2(DW);

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_INIT_LO,
    ST_INIT_HI,
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            phase_q, phase_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [BW-1:0]   nbits_q, nbits_d;
  logic            rw_q, rw_d;
  logic [SW-1:0]   sreg_q, sreg_d;
  logic [DW-1:0]   rx_q, rx_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic            init_done_q, init_done_d;
  logic            last_err_q, last_err_d;
  logic [2:0]      led_q, led_d;

  logic            nb_ok;
  logic [RXW-1:0]  rx_idx;

  assign nb_ok  = (cmd_nbytes != '0) && (cmd_nbytes <= LW'(MAX_BYTES));
  // Data bit d lands in byte d/8, bit 7-d%8: i.e. the low three index bits inverted.
  assign rx_idx = RXW'(bit_q - BW'(24)) ^ RXW'(7);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    nbits_d     = nbits_q;
    rw_d        = rw_q;
    sreg_d      = sreg_q;
    rx_d        = rx_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    pcnt_d      = pcnt_q;
    init_done_d = init_done_q;
    last_err_d  = last_err_q;

    case (state_q)
      ST_BOOT: begin
        cnt_d = '0;
        if (INIT_PULSES > 0) state_d = ST_INIT_LO;
        else                 state_d = ST_IDLE;
      end
      ST_INIT_LO: begin
        if (cnt_q == TW'(2 * CLK_DIV - 1)) begin
          cnt_d   = '0;
          state_d = ST_INIT_HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_INIT_HI: begin
        if (cnt_q == TW'(LATCH_GAP - 1)) begin
          cnt_d = '0;
          if (int'(pcnt_q) >= INIT_PULSES - 1) begin
            state_d = ST_IDLE;
          end else begin
            pcnt_d  = pcnt_q + 1'b1;
            state_d = ST_INIT_LO;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          if (nb_ok) begin
            rw_d    = cmd_rw;
            nbits_d = BW'(24 + 8 * int'(cmd_nbytes));
            sreg_d[SW-1 -: 24] = {CHIP_ADDR, cmd_rw, cmd_addr};
            for (int unsigned k = 0; k < MAX_BYTES; k++) begin
              sreg_d[DW-1-8*k -: 8] = cmd_rw ? 8'h00 : cmd_wdata[8*k +: 8];
            end
            rx_d    = '0;
            cnt_d   = '0;
            state_d = ST_SETUP;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            last_err_d  = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == TW'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == TW'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            if (rw_q && (bit_q >= BW'(24))) rx_d[rx_idx] = cout;
          end else if (bit_q == nbits_q - 1'b1) begin
            state_d = ST_HOLD;
          end else begin
            bit_d   = bit_q + 1'b1;
            phase_d = 1'b0;
            sreg_d  = {sreg_q[SW-2:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == TW'(CLK_DIV - 1)) begin
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          last_err_d  = 1'b0;
          if (rw_q) rdata_d = rx_q;
          state_d     = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == TW'(LATCH_GAP - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    if (state_d == ST_IDLE) init_done_d = 1'b1;
  end

  assign led_d = {init_done_d, state_d != ST_IDLE, last_err_d};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_BOOT;
      cnt_q       <= '0;
      phase_q     <= 1'b1;
      bit_q       <= '0;
      nbits_q     <= '0;
      rw_q        <= 1'b0;
      sreg_q      <= '0;
      rx_q        <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      pcnt_q      <= '0;
      init_done_q <= 1'b0;
      last_err_q  <= 1'b0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      nbits_q     <= nbits_d;
      rw_q        <= rw_d;
      sreg_q      <= sreg_d;
      rx_q        <= rx_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      pcnt_q      <= pcnt_d;
      init_done_q <= init_done_d;
      last_err_q  <= last_err_d;
      led_q       <= led_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign clatch_n  = !(state_q inside {ST_INIT_LO, ST_SETUP, ST_SHIFT, ST_HOLD});
  assign cclk      = !((state_q == ST_SHIFT) && !phase_q);
  assign cdata     = (state_q inside {ST_SETUP, ST_SHIFT, ST_HOLD}) ? sreg_q[SW-1] : 1'b0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rdata_q;
  assign led       = led_q;

endmodule

// File: tb/tb_adau_spi_burst_master.sv
// Directed bench for adau_spi_burst_master: init pulses, write/read frames,
// illegal lengths, back-to-back commands and mid-frame reset.
module tb_adau_spi_burst_master;

  localparam int LW = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rw = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [LW-1:0] cmd_nbytes = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        cout = 1'b0;
  logic        cdata, cclk, clatch_n, busy;
  logic [2:0]  led;

  adau_spi_burst_master #(
    .CLK_DIV(2), .MAX_BYTES(4), .CHIP_ADDR(7'h00), .INIT_PULSES(3), .LATCH_GAP(4)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_nbytes(cmd_nbytes), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .cout(cout), .cdata(cdata), .cclk(cclk), .clatch_n(clatch_n), .busy(busy), .led(led)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // Codec read pattern, MSB = frame bit 0; written only by the stimulus process.
  logic [63:0] rd_pat = '0;

  // Pin monitor / codec model state, written only by the monitor process.
  int          cyc = 0;
  int          lo_run = 0, last_lo_len = 0;
  int          last_rise_cyc = 0, last_spacing = 0;
  int          nfalls = 0, nrise = 0, ncf = 0, nrsp = 0, fi = 0;
  logic        rsp_err_last = 1'b0;
  int          rsp_cyc = 0;
  logic [63:0] rx_bits = '0;
  logic        prev_cl = 1'b1, prev_ck = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (clatch_n === 1'b0) begin
        if (prev_cl === 1'b1) begin
          nfalls++;
          last_spacing = cyc - last_rise_cyc;
          lo_run = 1;
        end else begin
          lo_run++;
        end
      end else begin
        if (prev_cl === 1'b0) begin
          last_lo_len   = lo_run;
          last_rise_cyc = cyc;
        end
        fi = 0;
      end
      if (cclk === 1'b1 && prev_ck === 1'b0) begin
        rx_bits = {rx_bits[62:0], cdata};
        nrise++;
      end
      if (cclk === 1'b0 && prev_ck === 1'b1) begin
        ncf++;
        if (clatch_n === 1'b0 && fi < 64) begin
          cout = rd_pat[63 - fi];
          fi++;
        end
      end
      if (rsp_valid === 1'b1) begin
        nrsp++;
        rsp_err_last = rsp_err;
        rsp_cyc = cyc;
      end
      prev_cl = clatch_n;
      prev_ck = cclk;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, ok, 1'b1);
  endtask

  task automatic wait_rsp(input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (nrsp >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("rsp_timeout", ok, 1'b1);
  endtask

  task automatic issue(input logic rw, input logic [15:0] a, input logic [LW-1:0] nb,
                       input logic [31:0] wd);
    cmd_rw = rw; cmd_addr = a; cmd_nbytes = nb; cmd_wdata = wd;
    cmd_valid = 1'b1;
    wait_ready("accept_timeout");
    tick();
    cmd_valid = 1'b0;
  endtask

  int f0, r0, c0, s0;

  initial begin
    // Reset values
    repeat (3) tick();
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_pins", {cdata, cclk, clatch_n}, 3'b011);
    chk("rst_busy", busy, 1'b1);
    chk("rst_led", led, 3'b000);

    // Init latch pulses
    f0 = nfalls; c0 = ncf;
    reset = 1'b0;
    wait_ready("init_timeout");
    chk("init_pulses", nfalls - f0, 3);
    chk("init_lo_len", last_lo_len, 4);
    chk("init_hi_len", last_spacing, 4);
    chk("init_ready_gap", cyc - last_rise_cyc, 4);
    chk("init_cclk_idle", ncf - c0, 0);
    chk("init_led", led, 3'b100);

    // Single-byte write
    r0 = nrise; s0 = nrsp;
    issue(1'b0, 16'h4000, 3'd1, 32'h0000_0001);
    wait_rsp(s0 + 1);
    chk("wr_rsp_at_rise", rsp_cyc, last_rise_cyc);
    repeat (8) tick();
    chk("wr_stream", rx_bits[31:0], 32'h0040_0001);
    chk("wr_nbits", nrise - r0, 32);
    chk("wr_lo_len", last_lo_len, 132);
    chk("wr_nrsp", nrsp - s0, 1);
    chk("wr_err", rsp_err_last, 1'b0);
    chk("wr_led", led, 3'b100);

    // Two-byte read
    rd_pat = {24'h0, 8'hA5, 8'h3C, 24'h0};
    r0 = nrise; s0 = nrsp;
    issue(1'b1, 16'h4002, 3'd2, 32'hDEAD_BEEF);
    wait_rsp(s0 + 1);
    chk("rd_rdata", rsp_rdata, 32'h0000_3CA5);
    chk("rd_err", rsp_err_last, 1'b0);
    repeat (8) tick();
    chk("rd_hdr", rx_bits[39:16], 24'h01_4002);
    chk("rd_cdata_zero", rx_bits[15:0], 16'h0);
    chk("rd_nbits", nrise - r0, 40);
    chk("rd_lo_len", last_lo_len, 164);

    // Illegal lengths
    f0 = nfalls; c0 = ncf; s0 = nrsp;
    issue(1'b0, 16'h1111, 3'd0, 32'h0);
    chk("ill0_rsp", {rsp_valid, rsp_err}, 2'b11);
    tick();
    chk("ill0_pulse", rsp_valid, 1'b0);
    issue(1'b1, 16'h2222, 3'd5, 32'h0);
    chk("ill5_rsp", {rsp_valid, rsp_err}, 2'b11);
    repeat (3) tick();
    chk("ill_nrsp", nrsp - s0, 2);
    chk("ill_no_latch", nfalls - f0, 0);
    chk("ill_no_cclk", ncf - c0, 0);
    chk("ill_led", led, 3'b101);
    chk("ill_rdata_hold", rsp_rdata, 32'h0000_3CA5);

    // Back-to-back writes with cmd_valid held
    f0 = nfalls; s0 = nrsp;
    cmd_rw = 1'b0; cmd_addr = 16'h1234; cmd_nbytes = 3'd1; cmd_wdata = 32'h0000_00AA;
    cmd_valid = 1'b1;
    wait_ready("b2b_a_timeout");
    tick();
    cmd_addr = 16'h0800; cmd_nbytes = 3'd2; cmd_wdata = 32'h0000_5566;
    tick();
    chk("b2b_ready_low", cmd_ready, 1'b0);
    wait_ready("b2b_b_timeout");
    chk("b2b_ready_gap", cyc - last_rise_cyc, 4);
    tick();
    cmd_valid = 1'b0;
    wait_rsp(s0 + 2);
    repeat (8) tick();
    chk("b2b_frames", nfalls - f0, 2);
    chk("b2b_spacing", last_spacing, 5);
    chk("b2b_stream", rx_bits[39:0], 40'h00_0800_6655);
    chk("b2b_nrsp", nrsp - s0, 2);
    chk("b2b_rdata_hold", rsp_rdata, 32'h0000_3CA5);

    // Reset during bit 10 of a frame
    c0 = ncf; s0 = nrsp;
    issue(1'b0, 16'hABCD, 3'd4, 32'h1234_5678);
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if (ncf - c0 >= 11) begin
          ok = 1'b1;
          break;
        end
        tick();
      end
      chk("bit10_timeout", ok, 1'b1);
    end
    reset = 1'b1;
    tick();
    chk("mid_rst_pins", {cclk, clatch_n}, 2'b11);
    chk("mid_rst_rsp", rsp_valid, 1'b0);
    chk("mid_rst_busy", {busy, cmd_ready}, 2'b10);
    chk("mid_rst_rdata", rsp_rdata, 32'h0);
    f0 = nfalls;
    reset = 1'b0;
    wait_ready("replay_timeout");
    chk("replay_pulses", nfalls - f0, 3);
    chk("replay_lo_len", last_lo_len, 4);
    chk("replay_no_rsp", nrsp - s0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
